// File: rtl/axi_rd_engine.sv
// AXI4 read engine: one INCR burst per command (length/4 KB checked), R beats forwarded to AXI-Stream.
// AR is issued two cycles after start; R->stream is combinational, so rready follows tready directly.
module axi_rd_engine #(
  parameter logic [3:0] ARID_VAL = 4'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        RSTART_REG,
  input  logic [31:0] RADDR_REG,
  input  logic [31:0] RLENGTH_REG,
  output logic        RIDLE_REG,
  output logic        RERR_REG,
  output logic [31:0] RCYCLES_REG,
  output logic [3:0]  m_axi_arid,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [63:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_CHECK = 5'b00010,
    S_ADDR  = 5'b00100,
    S_DATA  = 5'b01000,
    S_DONE  = 5'b10000
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] len_q, len_d;
  logic        err_q, err_d;
  logic [31:0] cycles_q, cycles_d;
  logic [8:0]  beat_q, beat_d;

  logic        len_zero, len_bad, cross_4k, beat_acc, at_len;
  logic [12:0] end_off;
  logic [8:0]  beat_inc;

  // len*8 only matters when len <= 256, so len[8:0] keeps the sum within 13 bits
  always_comb begin
    len_zero = (len_q == 32'd0);
    len_bad  = (len_q > 32'd256);
    end_off  = {1'b0, addr_q[11:0]} + {1'b0, len_q[8:0], 3'b000};
    cross_4k = (end_off > 13'd4096);
    beat_acc = (state_q == S_DATA) && m_axi_rvalid && m_axis_tready;
    beat_inc = beat_q + 9'd1;
    at_len   = ({23'd0, beat_inc} == len_q);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (RSTART_REG) state_d = S_CHECK;
      S_CHECK: state_d = (len_zero || len_bad || cross_4k) ? S_DONE : S_ADDR;
      S_ADDR:  if (m_axi_arready) state_d = S_DATA;
      S_DATA:  if (beat_acc && (m_axi_rlast || at_len)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    len_d    = len_q;
    err_d    = err_q;
    beat_d   = beat_q;
    cycles_d = (state_q == S_IDLE) ? cycles_q : cycles_q + 32'd1;
    case (state_q)
      S_IDLE: begin
        if (RSTART_REG) begin
          addr_d   = RADDR_REG & ~32'h7;
          len_d    = RLENGTH_REG;
          err_d    = 1'b0;
          cycles_d = 32'd0;
        end
      end
      S_CHECK: begin
        beat_d = 9'd0;
        if (!len_zero && (len_bad || cross_4k)) err_d = 1'b1;
      end
      S_DATA: begin
        // rlast must coincide exactly with the final requested beat
        if (beat_acc) begin
          beat_d = beat_inc;
          if ((m_axi_rresp != 2'b00) || (m_axi_rlast != at_len)) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q   <= 32'd0;
      len_q    <= 32'd0;
      err_q    <= 1'b0;
      cycles_q <= 32'd0;
      beat_q   <= 9'd0;
    end else begin
      addr_q   <= addr_d;
      len_q    <= len_d;
      err_q    <= err_d;
      cycles_q <= cycles_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    RIDLE_REG     = (state_q == S_IDLE);
    m_axi_arvalid = (state_q == S_ADDR);
    m_axi_rready  = (state_q == S_DATA) && m_axis_tready;
    m_axis_tvalid = (state_q == S_DATA) && m_axi_rvalid;
    m_axis_tlast  = (state_q == S_DATA) && m_axi_rlast;
  end

  assign RERR_REG      = err_q;
  assign RCYCLES_REG   = cycles_q;
  assign m_axi_arid    = ARID_VAL;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q[7:0] - 8'd1;
  assign m_axi_arsize  = 3'b011;
  assign m_axi_arburst = 2'b01;
  assign m_axis_tdata  = m_axi_rdata;

endmodule

// File: tb/tb_axi_rd_engine.sv
// Bench for axi_rd_engine: a cycle-level AXI slave/stream sink drives random beats while a
// rule-based model predicts the burst, forwarded stream, error flag and cycle count.
module tb_axi_rd_engine;

  localparam logic [3:0] ARID = 4'hA;

  logic        clk;
  logic        rstn;
  logic        RSTART_REG;
  logic [31:0] RADDR_REG;
  logic [31:0] RLENGTH_REG;
  logic        RIDLE_REG;
  logic        RERR_REG;
  logic [31:0] RCYCLES_REG;
  logic [3:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  axi_rd_engine #(.ARID_VAL(ARID)) dut (
    .clk(clk), .rstn(rstn),
    .RSTART_REG(RSTART_REG), .RADDR_REG(RADDR_REG), .RLENGTH_REG(RLENGTH_REG),
    .RIDLE_REG(RIDLE_REG), .RERR_REG(RERR_REG), .RCYCLES_REG(RCYCLES_REG),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int failed = 0;

  int          obs_ar_n, obs_proto;
  logic [31:0] obs_araddr, obs_cycles;
  logic [7:0]  obs_arlen;
  logic [3:0]  obs_arid;
  logic        obs_err;
  logic [63:0] obs_data[$];
  logic        obs_last[$];
  logic [63:0] exp_data[$];
  logic        exp_last[$];
  bit          mdl_traffic, mdl_err;
  logic [31:0] mdl_araddr;
  int          mdl_cycles;

  // Plays one command: slave offers beats, sink applies tready per mode; any deviation
  // from the expected per-cycle handshake picture is tallied in obs_proto.
  task automatic run_cmd(input logic [31:0] addr, input logic [31:0] len, input int ar_delay,
                         input int rlast_at, input int err_at, input int tready_mode,
                         input bit rv_rand, input int start_at);
    logic [31:0] a32, stab_addr;
    logic [7:0]  stab_len;
    logic [63:0] dat;
    int s, end_s, b, term;
    bit in_ar, in_data, rv, tr, hold, lst, term_done, fin;
    obs_ar_n = 0; obs_proto = 0; obs_err = 1'bx; obs_cycles = 'x;
    obs_araddr = 'x; obs_arlen = 'x; obs_arid = 'x;
    obs_data.delete(); obs_last.delete(); exp_data.delete(); exp_last.delete();
    a32 = addr & ~32'h7;
    mdl_araddr = a32;
    mdl_traffic = (len != 0) && (len <= 256) &&
                  ((longint'(a32) % 4096) + longint'(len) * 8 <= 4096);
    mdl_err = (len != 0) && !mdl_traffic;
    term = 0;
    if (mdl_traffic) begin
      term = (rlast_at >= 1 && rlast_at < int'(len)) ? rlast_at : int'(len);
      if (rlast_at != int'(len)) mdl_err = 1;
      if (err_at >= 1 && err_at <= term) mdl_err = 1;
    end
    @(posedge clk); #1;
    RSTART_REG = 1'b1; RADDR_REG = addr; RLENGTH_REG = len;
    @(posedge clk); #1;
    RSTART_REG = 1'b0; RADDR_REG = $urandom; RLENGTH_REG = $urandom;
    s = 0; end_s = mdl_traffic ? 32'h7fffffff : 2; b = 0;
    hold = 0; term_done = 0; fin = 0; stab_addr = 'x; stab_len = 'x;
    dat = {$urandom, $urandom};
    while (!fin) begin
      in_ar   = mdl_traffic && s >= 1 && s <= 1 + ar_delay;
      in_data = mdl_traffic && s >= 2 + ar_delay && !term_done;
      m_axi_arready = mdl_traffic && (s == 1 + ar_delay);
      if (tready_mode == 0)      tr = 1'b1;
      else if (tready_mode == 1) tr = ((s % 2) == 0);
      else                       tr = ($urandom_range(0, 1) == 1);
      m_axis_tready = tr;
      rv = (mdl_traffic && s >= 2 + ar_delay) &&
           (hold || term_done || !rv_rand || $urandom_range(0, 3) != 0);
      lst = (b + 1 == rlast_at);
      m_axi_rvalid = rv; m_axi_rdata = dat; m_axi_rlast = lst;
      m_axi_rresp = (b + 1 == err_at) ? 2'b10 : 2'b00;
      RSTART_REG = (s == start_at);
      if (s == start_at) begin RADDR_REG = 32'h2000; RLENGTH_REG = 32'd4; end
      @(negedge clk);
      if (RIDLE_REG !== (s == end_s)) obs_proto++;
      if (m_axi_arvalid !== in_ar) obs_proto++;
      if (in_ar) begin
        if (s == 1) begin stab_addr = m_axi_araddr; stab_len = m_axi_arlen; end
        if (m_axi_araddr !== stab_addr || m_axi_arlen !== stab_len) obs_proto++;
        if (m_axi_arid !== ARID || m_axi_arsize !== 3'b011 || m_axi_arburst !== 2'b01) obs_proto++;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        obs_ar_n++; obs_araddr = m_axi_araddr; obs_arlen = m_axi_arlen; obs_arid = m_axi_arid;
      end
      if (m_axi_rready !== (in_data && tr)) obs_proto++;
      if (m_axis_tvalid !== (in_data && rv)) obs_proto++;
      if (m_axis_tlast !== (in_data && lst)) obs_proto++;
      if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
        obs_data.push_back(m_axis_tdata); obs_last.push_back(m_axis_tlast);
      end
      if (s == end_s) begin
        obs_err = RERR_REG; obs_cycles = RCYCLES_REG; fin = 1;
      end else begin
        if (in_data && rv && tr) begin
          exp_data.push_back(dat); exp_last.push_back(lst);
          b++; hold = 0; dat = {$urandom, $urandom};
          if (b == term) begin term_done = 1; end_s = s + 2; end
        end else begin
          hold = rv && in_data;
        end
        s++;
        if (s > 3000) begin obs_proto++; fin = 1; end
        @(posedge clk); #1;
      end
    end
    mdl_cycles = end_s;
    @(posedge clk); #1;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 2'b00;
  endtask

  task automatic test_reset();
    rstn = 0; RSTART_REG = 0; RADDR_REG = 0; RLENGTH_REG = 0;
    m_axi_arready = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
    m_axi_rvalid = 0; m_axis_tready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (RIDLE_REG !== 1'b1) begin failed++; $display("FAIL rst_idle got %b want 1", RIDLE_REG); end
    tests_run++; if (RERR_REG !== 1'b0) begin failed++; $display("FAIL rst_err got %b want 0", RERR_REG); end
    tests_run++; if (RCYCLES_REG !== 32'd0) begin failed++; $display("FAIL rst_cycles got %0d want 0", RCYCLES_REG); end
    tests_run++; if (m_axi_arvalid !== 1'b0) begin failed++; $display("FAIL rst_arvalid got %b want 0", m_axi_arvalid); end
    tests_run++; if (m_axi_rready !== 1'b0) begin failed++; $display("FAIL rst_rready got %b want 0", m_axi_rready); end
    tests_run++; if (m_axis_tvalid !== 1'b0) begin failed++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
    tests_run++; if (m_axis_tlast !== 1'b0) begin failed++; $display("FAIL rst_tlast got %b want 0", m_axis_tlast); end
    @(posedge clk); #1; rstn = 1;
  endtask

  task automatic test_basic();
    bit bad;
    run_cmd(32'h0000_1000, 32'd8, 3, 8, 0, 0, 1'b0, -1);
    tests_run++; if (obs_ar_n !== 1) begin failed++; $display("FAIL basic_ar_count got %0d want 1", obs_ar_n); end
    tests_run++; if (obs_araddr !== 32'h1000) begin failed++; $display("FAIL basic_araddr got %h want 00001000", obs_araddr); end
    tests_run++; if (obs_arlen !== 8'd7) begin failed++; $display("FAIL basic_arlen got %0d want 7", obs_arlen); end
    tests_run++; if (obs_arid !== ARID) begin failed++; $display("FAIL basic_arid got %h want %h", obs_arid, ARID); end
    tests_run++; if (obs_data.size() != 8) begin failed++; $display("FAIL basic_beats got %0d want 8", obs_data.size()); end
    bad = (obs_data.size() != exp_data.size());
    foreach (exp_data[i]) if (!bad && (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])) bad = 1;
    tests_run++; if (bad) begin failed++; $display("FAIL basic_stream got %0d beats want %0d in order", obs_data.size(), exp_data.size()); end
    tests_run++; if (obs_err !== 1'b0) begin failed++; $display("FAIL basic_err got %b want 0", obs_err); end
    tests_run++; if (obs_cycles !== 32'd14) begin failed++; $display("FAIL basic_cycles got %0d want 14", obs_cycles); end
    tests_run++; if (obs_proto !== 0) begin failed++; $display("FAIL basic_proto got %0d violations want 0", obs_proto); end
  endtask

  task automatic test_cross4k();
    run_cmd(32'h0000_0FC0, 32'd16, 0, 16, 0, 0, 1'b0, -1);
    tests_run++; if (obs_ar_n !== 0) begin failed++; $display("FAIL cross_ar_count got %0d want 0", obs_ar_n); end
    tests_run++; if (obs_err !== 1'b1) begin failed++; $display("FAIL cross_err got %b want 1", obs_err); end
    tests_run++; if (obs_cycles !== 32'd2) begin failed++; $display("FAIL cross_cycles got %0d want 2", obs_cycles); end
    tests_run++; if (obs_proto !== 0) begin failed++; $display("FAIL cross_proto got %0d violations want 0", obs_proto); end
  endtask

  task automatic test_tready_toggle();
    bit bad;
    run_cmd(32'h0000_3040, 32'd8, 1, 8, 0, 1, 1'b0, -1);
    tests_run++; if (obs_data.size() != 8) begin failed++; $display("FAIL toggle_beats got %0d want 8", obs_data.size()); end
    bad = (obs_data.size() != exp_data.size());
    foreach (exp_data[i]) if (!bad && (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])) bad = 1;
    tests_run++; if (bad) begin failed++; $display("FAIL toggle_stream got %0d beats want %0d in order", obs_data.size(), exp_data.size()); end
    tests_run++; if (obs_err !== 1'b0) begin failed++; $display("FAIL toggle_err got %b want 0", obs_err); end
    tests_run++; if (obs_cycles !== mdl_cycles) begin failed++; $display("FAIL toggle_cycles got %0d want %0d", obs_cycles, mdl_cycles); end
    tests_run++; if (obs_proto !== 0) begin failed++; $display("FAIL toggle_proto got %0d violations want 0", obs_proto); end
  endtask

  task automatic test_rlast_errors();
    run_cmd(32'h0000_5000, 32'd8, 0, 5, 0, 0, 1'b1, -1);
    tests_run++; if (obs_data.size() != 5) begin failed++; $display("FAIL early_beats got %0d want 5", obs_data.size()); end
    tests_run++; if (obs_err !== 1'b1) begin failed++; $display("FAIL early_err got %b want 1", obs_err); end
    tests_run++; if (obs_proto !== 0) begin failed++; $display("FAIL early_proto got %0d violations want 0", obs_proto); end
    run_cmd(32'h0000_5100, 32'd8, 2, 8, 4, 0, 1'b1, -1);
    tests_run++; if (obs_data.size() != 8) begin failed++; $display("FAIL slverr_beats got %0d want 8", obs_data.size()); end
    tests_run++; if (obs_err !== 1'b1) begin failed++; $display("FAIL slverr_err got %b want 1", obs_err); end
    tests_run++; if (obs_proto !== 0) begin failed++; $display("FAIL slverr_proto got %0d violations want 0", obs_proto); end
    run_cmd(32'h0000_5200, 32'd8, 0, 0, 0, 0, 1'b0, -1);
    tests_run++; if (obs_data.size() != 8) begin failed++; $display("FAIL nolast_beats got %0d want 8", obs_data.size()); end
    tests_run++; if (obs_err !== 1'b1) begin failed++; $display("FAIL nolast_err got %b want 1", obs_err); end
    tests_run++; if (obs_proto !== 0) begin failed++; $display("FAIL nolast_proto got %0d violations want 0", obs_proto); end
  endtask

  task automatic test_len0();
    run_cmd(32'h0000_6000, 32'd0, 0, 0, 0, 0, 1'b0, -1);
    tests_run++; if (obs_ar_n !== 0) begin failed++; $display("FAIL len0_ar_count got %0d want 0", obs_ar_n); end
    tests_run++; if (obs_err !== 1'b0) begin failed++; $display("FAIL len0_err got %b want 0", obs_err); end
    tests_run++; if (obs_cycles !== 32'd2) begin failed++; $display("FAIL len0_cycles got %0d want 2", obs_cycles); end
    tests_run++; if (obs_proto !== 0) begin failed++; $display("FAIL len0_proto got %0d violations want 0", obs_proto); end
  endtask

  task automatic test_restart_ignored();
    run_cmd(32'h0000_3000, 32'd8, 1, 8, 0, 0, 1'b0, 5);
    tests_run++; if (obs_ar_n !== 1) begin failed++; $display("FAIL restart_ar_count got %0d want 1", obs_ar_n); end
    tests_run++; if (obs_araddr !== 32'h3000) begin failed++; $display("FAIL restart_araddr got %h want 00003000", obs_araddr); end
    tests_run++; if (obs_data.size() != 8) begin failed++; $display("FAIL restart_beats got %0d want 8", obs_data.size()); end
    tests_run++; if (obs_cycles !== mdl_cycles) begin failed++; $display("FAIL restart_cycles got %0d want %0d", obs_cycles, mdl_cycles); end
    tests_run++; if (obs_proto !== 0) begin failed++; $display("FAIL restart_proto got %0d violations want 0", obs_proto); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    RSTART_REG = 1; RADDR_REG = 32'h4000; RLENGTH_REG = 32'd8;
    @(posedge clk); #1;
    RSTART_REG = 0; m_axi_arready = 1; m_axis_tready = 1; m_axi_rvalid = 1;
    m_axi_rdata = {$urandom, $urandom}; m_axi_rlast = 0; m_axi_rresp = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (m_axi_rready !== 1'b1) begin failed++; $display("FAIL rmid_in_data got rready %b want 1", m_axi_rready); end
    rstn = 0;
    @(posedge clk); #1; rstn = 1;
    @(negedge clk);
    tests_run++; if (RIDLE_REG !== 1'b1) begin failed++; $display("FAIL rmid_idle got %b want 1", RIDLE_REG); end
    tests_run++; if (RCYCLES_REG !== 32'd0) begin failed++; $display("FAIL rmid_cycles got %0d want 0", RCYCLES_REG); end
    tests_run++; if (m_axi_rready !== 1'b0 || m_axis_tvalid !== 1'b0) begin failed++; $display("FAIL rmid_r got rready %b tvalid %b want 0 0", m_axi_rready, m_axis_tvalid); end
    tests_run++; if (m_axi_arvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin failed++; $display("FAIL rmid_ar got arvalid %b tlast %b want 0 0", m_axi_arvalid, m_axis_tlast); end
    m_axi_rvalid = 0; m_axi_arready = 0;
  endtask

  task automatic test_boundary();
    logic [31:0] ta [6];
    logic [31:0] tl [6];
    logic [31:0] tx [6];
    bit          tt [6];
    ta = '{32'h7800, 32'h7808, 32'h1FF8, 32'h1FFF, 32'h1FF8, 32'h9000};
    tl = '{32'd256,  32'd256,  32'd1,    32'd1,    32'd2,    32'd257};
    tx = '{32'h7800, 32'h0,    32'h1FF8, 32'h1FF8, 32'h0,    32'h0};
    tt = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
    for (int i = 0; i < 6; i++) begin
      run_cmd(ta[i], tl[i], i % 3, int'(tl[i]), 0, 0, 1'b0, -1);
      tests_run++; if (obs_ar_n !== (tt[i] ? 1 : 0)) begin failed++; $display("FAIL bnd%0d_ar_count got %0d want %0d", i, obs_ar_n, tt[i]); end
      tests_run++; if (obs_err !== !tt[i]) begin failed++; $display("FAIL bnd%0d_err got %b want %b", i, obs_err, !tt[i]); end
      if (tt[i]) begin
        tests_run++; if (obs_araddr !== tx[i]) begin failed++; $display("FAIL bnd%0d_araddr got %h want %h", i, obs_araddr, tx[i]); end
        tests_run++; if (obs_arlen !== 8'(tl[i] - 1)) begin failed++; $display("FAIL bnd%0d_arlen got %0d want %0d", i, obs_arlen, tl[i] - 1); end
      end
      tests_run++; if (obs_proto !== 0) begin failed++; $display("FAIL bnd%0d_proto got %0d violations want 0", i, obs_proto); end
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, len;
    int r, rl, ea;
    bit bad;
    for (int it = 0; it < 30; it++) begin
      addr = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0)      len = 32'd0;
      else if (r == 1) len = $urandom_range(257, 300);
      else if (r == 2) len = 32'd256;
      else             len = $urandom_range(1, 40);
      rl = int'(len); ea = 0;
      if (len >= 1 && len <= 256) begin
        r = $urandom_range(0, 5);
        if (r == 0)      rl = $urandom_range(1, int'(len));
        else if (r == 1) rl = 0;
        if ($urandom_range(0, 3) == 0) ea = $urandom_range(1, int'(len));
      end
      run_cmd(addr, len, $urandom_range(0, 4), rl, ea, 2, 1'b1, -1);
      tests_run++; if (obs_ar_n !== (mdl_traffic ? 1 : 0)) begin failed++; $display("FAIL rnd%0d_ar_count got %0d want %0d", it, obs_ar_n, mdl_traffic); end
      if (mdl_traffic) begin
        tests_run++; if (obs_araddr !== mdl_araddr || obs_arlen !== 8'(len - 1)) begin failed++; $display("FAIL rnd%0d_ar got %h/%0d want %h/%0d", it, obs_araddr, obs_arlen, mdl_araddr, len - 1); end
      end
      bad = (obs_data.size() != exp_data.size());
      foreach (exp_data[i]) if (!bad && (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])) bad = 1;
      tests_run++; if (bad) begin failed++; $display("FAIL rnd%0d_stream got %0d beats want %0d in order", it, obs_data.size(), exp_data.size()); end
      tests_run++; if (obs_err !== mdl_err) begin failed++; $display("FAIL rnd%0d_err got %b want %b", it, obs_err, mdl_err); end
      tests_run++; if (obs_cycles !== mdl_cycles) begin failed++; $display("FAIL rnd%0d_cycles got %0d want %0d", it, obs_cycles, mdl_cycles); end
      tests_run++; if (obs_proto !== 0) begin failed++; $display("FAIL rnd%0d_proto got %0d violations want 0", it, obs_proto); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cross4k();
    test_tready_toggle();
    test_rlast_errors();
    test_len0();
    test_restart_ignored();
    test_reset_mid();
    test_len0();
    test_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not complete, %0d checks done", tests_run);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_rd_engine.md
AXI_RD_ENGINE -- requirements
Module: axi_rd_engine

Interface
REQ-001 Parameter: ARID_VAL, default 4'h0, constant ARID driven on every burst.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 RSTART_REG  input  1  single-cycle command pulse; sampled only in IDLE.
REQ-005 RADDR_REG  input  32  byte start address of command.
REQ-006 RLENGTH_REG  input  32  command length in 64-bit beats.
REQ-007 RIDLE_REG  output  1  high only in IDLE.
REQ-008 RERR_REG  output  1  sticky command error flag.
REQ-009 RCYCLES_REG  output  32  cycles spent in current/last command.
REQ-010 m_axi_arid  output  4  read ID (= ARID_VAL).
REQ-011 m_axi_araddr  output  32  burst address.
REQ-012 m_axi_arlen  output  8  beats minus one.
REQ-013 m_axi_arsize  output  3  constant 3'b011 (8 bytes).
REQ-014 m_axi_arburst  output  2  constant 2'b01 (INCR).
REQ-015 m_axi_arvalid / m_axi_arready  output / input  1 / 1  AR handshake.
REQ-016 m_axi_rdata  input  64  read data.
REQ-017 m_axi_rresp / m_axi_rlast  input  2 / 1  response, last beat.
REQ-018 m_axi_rvalid / m_axi_rready  input / output  1 / 1  R handshake.
REQ-019 m_axis_tdata / m_axis_tlast  output  64 / 1  forwarded data, last beat.
REQ-020 m_axis_tvalid / m_axis_tready  output / input  1 / 1  stream handshake.

Function
REQ-021 FSM states IDLE, CHECK, ADDR, DATA, DONE; one-hot encoded.
REQ-022 IDLE: on RSTART_REG=1 latch addr={RADDR_REG[31:3],3'b000} and len=RLENGTH_REG, clear RERR_REG and RCYCLES_REG, go CHECK; RIDLE_REG=0 from next cycle.
REQ-023 RSTART_REG in any state other than IDLE shall be ignored.
REQ-024 CHECK (1 cycle): len=0 -> DONE, no AXI traffic, RERR_REG unchanged; len>256 or addr[11:0]+len*8>4096 (4 KB crossing, 13-bit arithmetic) -> RERR_REG=1, DONE; else ADDR.
REQ-025 ADDR: arvalid=1, araddr=addr, arlen=len-1 (8 bits); all AR outputs stable until arvalid&arready; then DATA next cycle.
REQ-026 DATA: m_axi_rready=m_axis_tready, m_axis_tvalid=m_axi_rvalid, tdata=rdata, tlast=rlast combinationally; zero added latency, no buffering.
REQ-027 Beat counter (9 bits) increments on each rvalid&rready; cleared on entry to ADDR.
REQ-028 Accepted beat with rresp!=2'b00 -> RERR_REG=1; transfer continues.
REQ-029 Accepted beat with rlast=1 before beat len -> RERR_REG=1, DONE.
REQ-030 Accepted beat len with rlast=0 -> RERR_REG=1, DONE; excess beats not accepted (rready=0 outside DATA).
REQ-031 Accepted beat len with rlast=1 -> DONE.
REQ-032 DONE: one cycle, then IDLE.
REQ-033 RCYCLES_REG increments every cycle state!=IDLE, holds in IDLE, wraps at 2^32.
REQ-034 Outside ADDR: arvalid=0; outside DATA: rready=0, tvalid=0, tlast=0.
REQ-035 At most one outstanding burst at any time.

Reset
REQ-036 rstn=0: state IDLE, RIDLE_REG=1, RERR_REG=0, RCYCLES_REG=0, arvalid=0, rready=0, tvalid=0, tlast=0, counters 0.
REQ-037 Reset mid-burst shall abort immediately without draining R beats; interconnect/slave reset together with this block.

Verification
REQ-038 addr=0x1000, len=8, arready delayed 3 cycles, tready=1 -> one AR (araddr 0x1000, arlen 7), 8 beats forwarded, tlast on beat 8, RERR_REG=0, RIDLE_REG low from cycle after start.
REQ-039 addr=0x0FC0, len=16 (crosses 4 KB) -> no arvalid, RERR_REG=1, RIDLE_REG returns high after CHECK+DONE; RCYCLES_REG=2.
REQ-040 len=8, tready toggling 1/0 every cycle -> rready mirrors tready, 8 beats, no beat lost or duplicated, data order preserved.
REQ-041 len=8, slave rlast on beat 5 -> RERR_REG=1, DONE after beat 5; beat 4 rresp=SLVERR variant -> RERR_REG=1, all 8 beats delivered.
REQ-042 RSTART_REG pulsed during DATA -> ignored, single AR; rstn=0 during DATA -> next cycle IDLE, all outputs at reset values.
REQ-043 len=0 -> no AXI traffic, RERR_REG=0, RIDLE_REG high 3 cycles after start.
